// File: rtl/cpu_defs.sv
// Shared bus definitions for the core's instruction/data masters and the
// single memory slave port: arbiter state encoding, request bundle, widths.
package cpu_defs;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_MASK_W = BUS_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2
  } ArbState_t;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [BUS_ADDR_W-1:0] address;
    logic [BUS_DATA_W-1:0] data_wr;
    logic [BUS_MASK_W-1:0] mask;
  } BusReq_t;

  // A master has a request outstanding whenever either strobe is high.
  function automatic logic req_pending(input BusReq_t req);
    return req.read | req.write;
  endfunction

endpackage

// File: rtl/bus_arbiter_2to1.sv
// bus_arbiter_2to1: shares one non-split memory slave port between the
// instruction-fetch master and the data-access master. Data wins arbitration;
// the granted master's request is forwarded combinationally and owns the
// slave until it completes (request high with mem_stall low) or withdraws.
// Arbitration is registered, so every completion is followed by one IDLE cycle.
//
// Build option: define ARB_STARVE_GUARD_EN to add the instruction
// anti-starvation counter; after STARVE_LIMIT consecutive data grants taken
// while an instruction request waits, the instruction master wins once.
module bus_arbiter_2to1
  import cpu_defs::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // instruction master
  input  logic                  i_ibus_read,
  input  logic                  i_ibus_write,
  input  logic [BUS_ADDR_W-1:0] i_ibus_address,
  input  logic [BUS_DATA_W-1:0] i_ibus_data_wr,
  input  logic [BUS_MASK_W-1:0] i_ibus_mask,
  output logic [BUS_DATA_W-1:0] o_ibus_data_rd,
  output logic                  o_ibus_stall,
  // data master
  input  logic                  i_dbus_read,
  input  logic                  i_dbus_write,
  input  logic [BUS_ADDR_W-1:0] i_dbus_address,
  input  logic [BUS_DATA_W-1:0] i_dbus_data_wr,
  input  logic [BUS_MASK_W-1:0] i_dbus_mask,
  output logic [BUS_DATA_W-1:0] o_dbus_data_rd,
  output logic                  o_dbus_stall,
  // shared slave
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [BUS_ADDR_W-1:0] o_mem_address,
  output logic [BUS_DATA_W-1:0] o_mem_data_wr,
  output logic [BUS_MASK_W-1:0] o_mem_mask,
  input  logic [BUS_DATA_W-1:0] i_mem_data_rd,
  input  logic                  i_mem_stall,
  // observability
  output logic                  o_grant_inst,
  output logic                  o_grant_data
);

  BusReq_t   w_ireq;
  BusReq_t   w_dreq;
  BusReq_t   w_sel_req;
  logic      w_ipend;
  logic      w_dpend;
  logic      w_inst_owner;
  logic      w_data_owner;
  logic      w_starve_hit;
  ArbState_t r_state;
  ArbState_t w_state_nxt;
  logic      r_grant_inst;
  logic      r_grant_data;

  assign w_ireq  = {i_ibus_read, i_ibus_write, i_ibus_address, i_ibus_data_wr, i_ibus_mask};
  assign w_dreq  = {i_dbus_read, i_dbus_write, i_dbus_address, i_dbus_data_wr, i_dbus_mask};
  assign w_ipend = req_pending(w_ireq);
  assign w_dpend = req_pending(w_dreq);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;

  assign w_starve_hit = (r_starve_cnt == STARVE_LIMIT_C);

  // Count data grants taken over a waiting fetch; any fetch grant or idle fetch clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= 4'd0;
    end else if (r_state == IDLE) begin
      if (!w_ipend || (w_state_nxt == INST_BUSY)) begin
        r_starve_cnt <= 4'd0;
      end else if ((w_state_nxt == DATA_BUSY) && (r_starve_cnt != STARVE_LIMIT_C)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  assign w_starve_hit = 1'b0;
`endif

  // State and grant registers; grants mirror the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_grant_inst <= 1'b0;
      r_grant_data <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_inst <= (w_state_nxt == INST_BUSY);
      r_grant_data <= (w_state_nxt == DATA_BUSY);
    end
  end

  // Next-state: arbitrate in IDLE, leave BUSY on completion or on withdrawal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_ipend && w_starve_hit) begin
          w_state_nxt = INST_BUSY;
        end else if (w_dpend) begin
          w_state_nxt = DATA_BUSY;
        end else if (w_ipend) begin
          w_state_nxt = INST_BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      INST_BUSY: begin
        if (!w_ipend || !i_mem_stall) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = INST_BUSY;
        end
      end
      DATA_BUSY: begin
        if (!w_dpend || !i_mem_stall) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DATA_BUSY;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output select: forward the owner's request; nothing reaches the slave in IDLE or reset.
  always_comb begin
    w_sel_req    = '0;
    w_inst_owner = 1'b0;
    w_data_owner = 1'b0;
    if (i_rst) begin
      w_sel_req    = '0;
      w_inst_owner = 1'b0;
      w_data_owner = 1'b0;
    end else begin
      case (r_state)
        INST_BUSY: begin
          w_sel_req    = w_ireq;
          w_inst_owner = 1'b1;
        end
        DATA_BUSY: begin
          w_sel_req    = w_dreq;
          w_data_owner = 1'b1;
        end
        default: begin
          w_sel_req    = '0;
          w_inst_owner = 1'b0;
          w_data_owner = 1'b0;
        end
      endcase
    end
  end

  // A master issuing read and write together is treated as a write.
  assign o_mem_read     = w_sel_req.read & ~w_sel_req.write;
  assign o_mem_write    = w_sel_req.write;
  assign o_mem_address  = w_sel_req.address;
  assign o_mem_data_wr  = w_sel_req.data_wr;
  assign o_mem_mask     = w_sel_req.mask;

  assign o_ibus_stall   = w_ipend & ~(w_inst_owner & ~i_mem_stall);
  assign o_dbus_stall   = w_dpend & ~(w_data_owner & ~i_mem_stall);
  assign o_ibus_data_rd = w_inst_owner ? i_mem_data_rd : 32'h0000_0000;
  assign o_dbus_data_rd = w_data_owner ? i_mem_data_rd : 32'h0000_0000;

  assign o_grant_inst   = r_grant_inst;
  assign o_grant_data   = r_grant_data;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed bench for bus_arbiter_2to1. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1-2 time units after the edge.
module tb_bus_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_read, ibus_write, dbus_read, dbus_write;
  logic [31:0] ibus_address, ibus_data_wr, dbus_address, dbus_data_wr;
  logic [3:0]  ibus_mask, dbus_mask;
  logic [31:0] ibus_data_rd, dbus_data_rd;
  logic        ibus_stall, dbus_stall;
  logic        mem_read, mem_write, mem_stall;
  logic [31:0] mem_address, mem_data_wr, mem_data_rd;
  logic [3:0]  mem_mask;
  logic        grant_inst, grant_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter_2to1 #(.STARVE_LIMIT(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_ibus_read    (ibus_read),
    .i_ibus_write   (ibus_write),
    .i_ibus_address (ibus_address),
    .i_ibus_data_wr (ibus_data_wr),
    .i_ibus_mask    (ibus_mask),
    .o_ibus_data_rd (ibus_data_rd),
    .o_ibus_stall   (ibus_stall),
    .i_dbus_read    (dbus_read),
    .i_dbus_write   (dbus_write),
    .i_dbus_address (dbus_address),
    .i_dbus_data_wr (dbus_data_wr),
    .i_dbus_mask    (dbus_mask),
    .o_dbus_data_rd (dbus_data_rd),
    .o_dbus_stall   (dbus_stall),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_mem_address  (mem_address),
    .o_mem_data_wr  (mem_data_wr),
    .o_mem_mask     (mem_mask),
    .i_mem_data_rd  (mem_data_rd),
    .i_mem_stall    (mem_stall),
    .o_grant_inst   (grant_inst),
    .o_grant_data   (grant_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int dcnt;
  int icnt;
  int d_before_i;

  initial begin
    rst = 1'b1;
    ibus_read = 1'b0; ibus_write = 1'b0; ibus_address = 32'h0; ibus_data_wr = 32'h0; ibus_mask = 4'h0;
    dbus_read = 1'b0; dbus_write = 1'b0; dbus_address = 32'h0; dbus_data_wr = 32'h0; dbus_mask = 4'h0;
    mem_stall = 1'b0; mem_data_rd = 32'h0;

    // reset state, fetch requesting throughout
    ibus_read = 1'b1; ibus_address = 32'h0000_1111;
    cyc(); cyc(); settle();
    chk("rst_ibus_stall", {31'h0, ibus_stall}, 32'h1);
    chk("rst_mem_read",   {31'h0, mem_read},   32'h0);
    chk("rst_mem_addr",   mem_address,         32'h0);
    chk("rst_grant_inst", {31'h0, grant_inst}, 32'h0);
    chk("rst_grant_data", {31'h0, grant_data}, 32'h0);
    chk("rst_ibus_rd",    ibus_data_rd,        32'h0);
    ibus_read = 1'b0;
    cyc();
    rst = 1'b0;
    cyc(); cyc();

    // single fetch read, zero-wait slave
    ibus_read = 1'b1; ibus_address = 32'h0000_1000; mem_data_rd = 32'hDEAD_BEEF;
    settle();
    chk("t1_stall_n",   {31'h0, ibus_stall}, 32'h1);
    chk("t1_memrd_n",   {31'h0, mem_read},   32'h0);
    chk("t1_ibus_rd_n", ibus_data_rd,        32'h0);
    cyc();
    chk("t1_memrd",  {31'h0, mem_read},   32'h1);
    chk("t1_memwr",  {31'h0, mem_write},  32'h0);
    chk("t1_addr",   mem_address,         32'h0000_1000);
    chk("t1_rdata",  ibus_data_rd,        32'hDEAD_BEEF);
    chk("t1_stall",  {31'h0, ibus_stall}, 32'h0);
    chk("t1_grant",  {31'h0, grant_inst}, 32'h1);
    ibus_read = 1'b0;
    cyc();
    chk("t1_idle_grant", {31'h0, grant_inst}, 32'h0);
    chk("t1_idle_memrd", {31'h0, mem_read},   32'h0);
    cyc();

    // both request; data first, fetch after one idle cycle
    ibus_read = 1'b1; ibus_address = 32'h0000_3000;
    dbus_write = 1'b1; dbus_address = 32'h0000_2000; dbus_data_wr = 32'h1234_5678; dbus_mask = 4'hF;
    mem_data_rd = 32'hA5A5_A5A5;
    settle();
    chk("t2_istall_n", {31'h0, ibus_stall}, 32'h1);
    chk("t2_dstall_n", {31'h0, dbus_stall}, 32'h1);
    cyc();
    chk("t2_grant_d",  {31'h0, grant_data}, 32'h1);
    chk("t2_grant_i",  {31'h0, grant_inst}, 32'h0);
    chk("t2_memwr",    {31'h0, mem_write},  32'h1);
    chk("t2_memrd",    {31'h0, mem_read},   32'h0);
    chk("t2_addr",     mem_address,         32'h0000_2000);
    chk("t2_wdata",    mem_data_wr,         32'h1234_5678);
    chk("t2_mask",     {28'h0, mem_mask},   32'h0000_000F);
    chk("t2_dstall",   {31'h0, dbus_stall}, 32'h0);
    chk("t2_istall",   {31'h0, ibus_stall}, 32'h1);
    chk("t2_ibus_rd",  ibus_data_rd,        32'h0);
    chk("t2_dbus_rd",  dbus_data_rd,        32'hA5A5_A5A5);
    dbus_write = 1'b0;
    cyc();
    chk("t2_bubble_gi", {31'h0, grant_inst}, 32'h0);
    chk("t2_bubble_rd", {31'h0, mem_read},   32'h0);
    chk("t2_bubble_is", {31'h0, ibus_stall}, 32'h1);
    cyc();
    chk("t2_grant_i2", {31'h0, grant_inst}, 32'h1);
    chk("t2_addr2",    mem_address,         32'h0000_3000);
    chk("t2_memrd2",   {31'h0, mem_read},   32'h1);
    ibus_read = 1'b0;
    cyc(); cyc();

    // data read with three slave wait states
    dbus_read = 1'b1; dbus_address = 32'h0000_4000; dbus_mask = 4'h3; mem_stall = 1'b1;
    settle();
    chk("t3_stall_c0", {31'h0, dbus_stall}, 32'h1);
    for (int w = 1; w <= 3; w++) begin
      cyc();
      chk("t3_stall_w", {31'h0, dbus_stall}, 32'h1);
      chk("t3_memrd_w", {31'h0, mem_read},   32'h1);
      chk("t3_addr_w",  mem_address,         32'h0000_4000);
      chk("t3_mask_w",  {28'h0, mem_mask},   32'h0000_0003);
    end
    cyc();
    mem_stall = 1'b0; mem_data_rd = 32'h0BAD_F00D;
    settle();
    chk("t3_done_stall", {31'h0, dbus_stall}, 32'h0);
    chk("t3_done_rdata", dbus_data_rd,        32'h0BAD_F00D);
    chk("t3_done_addr",  mem_address,         32'h0000_4000);
    dbus_read = 1'b0;
    cyc(); cyc();

    // data continuously requesting while fetch waits
    dbus_read = 1'b1; ibus_read = 1'b1; ibus_address = 32'h0000_7000;
    dcnt = 0; icnt = 0; d_before_i = -1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (grant_inst && d_before_i < 0) d_before_i = dcnt;
      if (grant_data) dcnt++;
      if (grant_inst) icnt++;
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("t4_data_before_inst", d_before_i, 32'd4);
`else
    chk("t4_inst_grants", icnt, 32'd0);
    chk("t4_data_grants", dcnt, 32'd10);
`endif
    dbus_read = 1'b0; ibus_read = 1'b0;
    cyc(); cyc(); cyc();

    // reset during a stalled data access
    dbus_read = 1'b1; dbus_address = 32'h0000_5000; mem_stall = 1'b1;
    cyc();
    chk("t5_memrd_busy", {31'h0, mem_read}, 32'h1);
    rst = 1'b1;
    settle();
    chk("t5_memrd_rst", {31'h0, mem_read},   32'h0);
    chk("t5_addr_rst",  mem_address,         32'h0);
    chk("t5_stall_rst", {31'h0, dbus_stall}, 32'h1);
    chk("t5_drd_rst",   dbus_data_rd,        32'h0);
    cyc();
    chk("t5_grant_rst", {31'h0, grant_data}, 32'h0);
    chk("t5_memrd_rst2", {31'h0, mem_read},  32'h0);
    rst = 1'b0;
    settle();
    chk("t5_memrd_idle", {31'h0, mem_read},   32'h0);
    chk("t5_stall_idle", {31'h0, dbus_stall}, 32'h1);
    cyc();
    chk("t5_regrant",   {31'h0, grant_data}, 32'h1);
    chk("t5_readdr",    mem_address,         32'h0000_5000);
    mem_stall = 1'b0;
    settle();
    chk("t5_done",      {31'h0, dbus_stall}, 32'h0);
    dbus_read = 1'b0;
    cyc(); cyc();

    // fetch withdraws mid-access; waiting data gets the bus after the bubble
    ibus_read = 1'b1; ibus_address = 32'h0000_6000; mem_stall = 1'b1;
    cyc();
    chk("t6_memrd_busy", {31'h0, mem_read}, 32'h1);
    dbus_read = 1'b1; dbus_address = 32'h0000_6100;
    settle();
    chk("t6_dstall_wait", {31'h0, dbus_stall}, 32'h1);
    ibus_read = 1'b0;
    settle();
    chk("t6_memrd_drop", {31'h0, mem_read},   32'h0);
    chk("t6_istall_drop", {31'h0, ibus_stall}, 32'h0);
    cyc();
    chk("t6_idle_gi", {31'h0, grant_inst}, 32'h0);
    chk("t6_idle_gd", {31'h0, grant_data}, 32'h0);
    cyc();
    chk("t6_grant_d", {31'h0, grant_data}, 32'h1);
    chk("t6_addr_d",  mem_address,         32'h0000_6100);
    mem_stall = 1'b0;
    dbus_read = 1'b0;
    cyc(); cyc();

    // read and write together from one master: write wins
    dbus_read = 1'b1; dbus_write = 1'b1; dbus_address = 32'h0000_8000;
    cyc();
    chk("t7_memwr", {31'h0, mem_write}, 32'h1);
    chk("t7_memrd", {31'h0, mem_read},  32'h0);
    dbus_read = 1'b0; dbus_write = 1'b0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
